maze_link_receiver: RTL and testbench

- Receives maze-cell updates from the Arduino over the narrow parallel GPIO link: a data group, a strobe and a cell address.
- Each strobe carries one DATA_BITS chunk. CHUNKS strobes to the same address form one cell word.
- Synchronises the asynchronous link into the CLOCK domain and assembles chunks LSB-first.
- Emits a single-cycle registered write to the VGA cell RAM, with timeout recovery and error/word statistics.

---
 rtl/maze_link_pkg.sv | 27 ++
 rtl/maze_link_if.sv | 30 +++
 rtl/maze_link_receiver_sync.sv | 38 +++
 rtl/maze_link_receiver.sv | 203 ++++++++++++++++++++
 tb/tb_maze_link_receiver.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_link_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// maze_link_pkg : shared types and defaults for the maze link receiver
// Rev 1.0
// ------------------------------------------------------------------
package maze_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Error causes exported for debug tooling; the receiver only counts errors.
  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_RANGE       = 2'd1,
    ERR_ADDR_CHANGE = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } err_cause_e;

  localparam int unsigned DEF_CLK_HZ         = 25_000_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = DEF_CLK_HZ / 10;
  localparam int unsigned DEF_NUM_CELLS      = 20;

endpackage : maze_link_pkg
`default_nettype wire

// File: rtl/maze_link_if.sv
`default_nettype none
// ------------------------------------------------------------------
// maze_link_if : Arduino GPIO link plus cell-RAM write port
// Rev 1.0
// ------------------------------------------------------------------
interface maze_link_if #(
  parameter int DATA_BITS = 3,
  parameter int CHUNKS    = 3,
  parameter int ADDR_BITS = 5
) ();

  logic [DATA_BITS-1:0]        LINK_DATA;
  logic                        LINK_STROBE;
  logic [ADDR_BITS-1:0]        LINK_ADDR;
  logic                        WR_EN;
  logic [ADDR_BITS-1:0]        WR_ADDR;
  logic [DATA_BITS*CHUNKS-1:0] WR_DATA;

  modport master (
    output LINK_DATA, LINK_STROBE, LINK_ADDR,
    input  WR_EN, WR_ADDR, WR_DATA
  );

  modport slave (
    input  LINK_DATA, LINK_STROBE, LINK_ADDR,
    output WR_EN, WR_ADDR, WR_DATA
  );

endinterface : maze_link_if
`default_nettype wire

// File: rtl/maze_link_receiver_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// link_sync : N-stage synchroniser with registered rising-edge detect
// Rev 1.0
// ------------------------------------------------------------------
module link_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             prev_q;
  logic [WIDTH-1:0]             rise_q;

  // q_o is the delayed copy so that it lines up with the registered rise_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign q_o    = prev_q;
  assign rise_o = rise_q;

endmodule : link_sync
`default_nettype wire

// File: rtl/maze_link_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// maze_link_receiver : assembles GPIO link chunks into cell-RAM writes
// Rev 1.0
// ------------------------------------------------------------------
module maze_link_receiver
  import maze_link_pkg::*;
#(
  parameter int DATA_BITS      = 3,
  parameter int CHUNKS         = 3,
  parameter int ADDR_BITS      = 5,
  parameter int NUM_CELLS      = DEF_NUM_CELLS,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  maze_link_if.slave  link,
  input  logic        CLEAR,
  output logic        BUSY,
  output logic [15:0] WORD_COUNT,
  output logic [7:0]  ERR_COUNT,
  output logic        ERR_FLAG
);

  localparam int WORD_W = DATA_BITS * CHUNKS;
  localparam int IDX_W  = $clog2(CHUNKS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0]           c_IDLE      = ST_IDLE;
  localparam logic [1:0]           c_ACCUM     = ST_ACCUM;
  localparam logic [1:0]           c_COMMIT    = ST_COMMIT;
  localparam logic [ADDR_BITS:0]   c_NUM_CELLS = (ADDR_BITS + 1)'(NUM_CELLS);
  localparam logic [IDX_W-1:0]     c_LAST_IDX  = IDX_W'(CHUNKS - 1);
  localparam logic [TMO_W-1:0]     c_TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [1:0]           c_FIRST_NXT = (CHUNKS == 1) ? c_COMMIT : c_ACCUM;

  logic                  w_edge;
  logic                  w_strb_lvl_unused;
  logic [ADDR_BITS+DATA_BITS-1:0] w_bus;
  logic [ADDR_BITS+DATA_BITS-1:0] w_bus_rise_unused;
  logic [ADDR_BITS-1:0]  w_addr;
  logic [DATA_BITS-1:0]  w_chunk;
  logic                  w_addr_bad;
  logic                  w_start;
  logic                  w_err;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     asm_q, asm_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  wr_en_q;
  logic [ADDR_BITS-1:0]  wr_addr_q;
  logic [WORD_W-1:0]     wr_data_q;
  logic [15:0]           word_cnt_q;
  logic [7:0]            err_cnt_q;
  logic                  err_flag_q;

  link_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .d_i    (link.LINK_STROBE),
    .q_o    (w_strb_lvl_unused),
    .rise_o (w_edge)
  );

  link_sync #(
    .WIDTH  (ADDR_BITS + DATA_BITS),
    .STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .d_i    ({link.LINK_ADDR, link.LINK_DATA}),
    .q_o    (w_bus),
    .rise_o (w_bus_rise_unused)
  );

  assign w_addr     = w_bus[ADDR_BITS+DATA_BITS-1:DATA_BITS];
  assign w_chunk    = w_bus[DATA_BITS-1:0];
  assign w_addr_bad = ({1'b0, w_addr} >= c_NUM_CELLS);

  // Any edge that is not a same-address continuation starts a fresh word,
  // including an edge that lands in the COMMIT cycle.
  assign w_start = w_edge && !((state_q == c_ACCUM) && (w_addr == addr_q));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    tmo_d   = '0;
    w_err   = 1'b0;

    if (state_q == c_COMMIT) begin
      state_d = c_IDLE;
    end

    if (state_q == c_ACCUM) begin
      if (w_edge && (w_addr == addr_q)) begin
        for (int k = 0; k < CHUNKS; k++) begin
          if (idx_q == IDX_W'(k)) begin
            asm_d[k*DATA_BITS +: DATA_BITS] = w_chunk;
          end
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == c_LAST_IDX) begin
          state_d = c_COMMIT;
        end
      end else if (w_edge) begin
        w_err = 1'b1;
      end else if (tmo_q == c_TMO_MAX) begin
        w_err   = 1'b1;
        state_d = c_IDLE;
        asm_d   = '0;
        idx_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (w_start) begin
      asm_d = '0;
      if (w_addr_bad) begin
        w_err   = 1'b1;
        state_d = c_IDLE;
        idx_d   = '0;
      end else begin
        asm_d[DATA_BITS-1:0] = w_chunk;
        addr_d  = w_addr;
        idx_d   = IDX_W'(1);
        state_d = c_FIRST_NXT;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= c_IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
    end
  end

  // The write port samples the assembly registers on the edge leaving COMMIT.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= (state_q == c_COMMIT);
      if (state_q == c_COMMIT) begin
        wr_addr_q <= addr_q;
        wr_data_q <= asm_q;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else if (CLEAR) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      if ((state_q == c_COMMIT) && (word_cnt_q != 16'hFFFF)) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      if (w_err) begin
        err_flag_q <= 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign link.WR_EN   = wr_en_q;
  assign link.WR_ADDR = wr_addr_q;
  assign link.WR_DATA = wr_data_q;
  assign BUSY         = (state_q == c_ACCUM);
  assign WORD_COUNT   = word_cnt_q;
  assign ERR_COUNT    = err_cnt_q;
  assign ERR_FLAG     = err_flag_q;

endmodule : maze_link_receiver
`default_nettype wire

// File: tb/tb_maze_link_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_maze_link_receiver : directed table-driven bench for the receiver
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_maze_link_receiver;

  localparam int SS  = 2;
  localparam int TMO = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  always #5 clk = ~clk;

  maze_link_if #(.DATA_BITS(3), .CHUNKS(3), .ADDR_BITS(5)) lnk_a ();
  maze_link_if #(.DATA_BITS(8), .CHUNKS(1), .ADDR_BITS(5)) lnk_b ();

  logic        busy_a, flag_a, busy_b, flag_b;
  logic [15:0] wc_a, wc_b;
  logic [7:0]  ec_a, ec_b;

  maze_link_receiver #(
    .DATA_BITS(3), .CHUNKS(3), .ADDR_BITS(5), .NUM_CELLS(20),
    .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
  ) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .link(lnk_a), .CLEAR(clr_a),
    .BUSY(busy_a), .WORD_COUNT(wc_a), .ERR_COUNT(ec_a), .ERR_FLAG(flag_a)
  );

  maze_link_receiver #(
    .DATA_BITS(8), .CHUNKS(1), .ADDR_BITS(5), .NUM_CELLS(30),
    .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
  ) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .link(lnk_b), .CLEAR(clr_b),
    .BUSY(busy_b), .WORD_COUNT(wc_b), .ERR_COUNT(ec_b), .ERR_FLAG(flag_b)
  );

  typedef struct {
    logic [4:0] addr;
    logic [2:0] d0, d1, d2;
    int         wr;
    logic [4:0] eaddr;
    logic [8:0] edata;
    int         errinc;
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wr_a     = 0;
  int   wr_b     = 0;

  always @(negedge clk) begin
    if (lnk_a.WR_EN === 1'b1) wr_a++;
    if (lnk_b.WR_EN === 1'b1) wr_b++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [4:0] a, input logic [2:0] d, input int hi, input int lo);
    @(negedge clk);
    lnk_a.LINK_ADDR   = a;
    lnk_a.LINK_DATA   = d;
    lnk_a.LINK_STROBE = 1'b1;
    repeat (hi) @(negedge clk);
    lnk_a.LINK_STROBE = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic send_b(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    lnk_b.LINK_ADDR   = a;
    lnk_b.LINK_DATA   = d;
    lnk_b.LINK_STROBE = 1'b1;
    repeat (4) @(negedge clk);
    lnk_b.LINK_STROBE = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic word_a(input logic [4:0] a, input logic [2:0] d0, input logic [2:0] d1,
                        input logic [2:0] d2);
    send_a(a, d0, 4, 4);
    send_a(a, d1, 4, 4);
    send_a(a, d2, 4, 4);
  endtask

  task automatic clear_a();
    @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int exp_words;
    int exp_errs;

    tbl[0] = '{5'd1,  3'd3, 3'd6, 3'd0, 1, 5'd1,  9'h033, 0};
    tbl[1] = '{5'd0,  3'd0, 3'd0, 3'd0, 1, 5'd0,  9'h000, 0};
    tbl[2] = '{5'd19, 3'd7, 3'd7, 3'd7, 1, 5'd19, 9'h1FF, 0};
    tbl[3] = '{5'd20, 3'd1, 3'd2, 3'd3, 0, 5'd19, 9'h1FF, 3};
    tbl[4] = '{5'd31, 3'd4, 3'd4, 3'd4, 0, 5'd19, 9'h1FF, 3};
    tbl[5] = '{5'd12, 3'd1, 3'd0, 3'd6, 1, 5'd12, 9'h181, 0};

    lnk_a.LINK_ADDR = '0; lnk_a.LINK_DATA = '0; lnk_a.LINK_STROBE = 1'b0;
    lnk_b.LINK_ADDR = '0; lnk_b.LINK_DATA = '0; lnk_b.LINK_STROBE = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sample_pt();

    check("rst_wr_en",   32'(lnk_a.WR_EN),   32'(0));
    check("rst_wr_addr", 32'(lnk_a.WR_ADDR), 32'(0));
    check("rst_wr_data", 32'(lnk_a.WR_DATA), 32'(0));
    check("rst_busy",    32'(busy_a),        32'(0));
    check("rst_words",   32'(wc_a),          32'(0));
    check("rst_errs",    32'(ec_a),          32'(0));
    check("rst_flag",    32'(flag_a),        32'(0));

    // Nominal word with a cycle-exact latency check on the final chunk.
    w0 = wr_a;
    send_a(5'd7, 3'b101, 4, 4);
    send_a(5'd7, 3'b010, 4, 4);
    @(negedge clk);
    lnk_a.LINK_ADDR = 5'd7; lnk_a.LINK_DATA = 3'b111; lnk_a.LINK_STROBE = 1'b1;
    @(posedge clk);
    repeat (SS + 1) @(posedge clk);
    #1;
    check("lat_early", 32'(lnk_a.WR_EN), 32'(0));
    @(posedge clk);
    #1;
    check("lat_on",      32'(lnk_a.WR_EN),   32'(1));
    check("nom_wr_addr", 32'(lnk_a.WR_ADDR), 32'(7));
    check("nom_wr_data", 32'(lnk_a.WR_DATA), 32'(9'b111_010_101));
    check("nom_words",   32'(wc_a),          32'(1));
    @(negedge clk);
    lnk_a.LINK_STROBE = 1'b0;
    repeat (4) @(negedge clk);
    sample_pt();
    check("nom_pulses", 32'(wr_a - w0), 32'(1));
    check("nom_errs",   32'(ec_a),      32'(0));
    check("nom_flag",   32'(flag_a),    32'(0));

    exp_words = 1;
    exp_errs  = 0;
    for (int i = 0; i < 6; i++) begin
      w0 = wr_a;
      word_a(tbl[i].addr, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      sample_pt();
      exp_words += tbl[i].wr;
      exp_errs  += tbl[i].errinc;
      check($sformatf("tbl%0d_pulses", i),  32'(wr_a - w0),      32'(tbl[i].wr));
      check($sformatf("tbl%0d_wr_addr", i), 32'(lnk_a.WR_ADDR),  32'(tbl[i].eaddr));
      check($sformatf("tbl%0d_wr_data", i), 32'(lnk_a.WR_DATA),  32'(tbl[i].edata));
      check($sformatf("tbl%0d_words", i),   32'(wc_a),           32'(exp_words));
      check($sformatf("tbl%0d_errs", i),    32'(ec_a),           32'(exp_errs));
      check($sformatf("tbl%0d_busy", i),    32'(busy_a),         32'(0));
    end

    // Address change mid-word.
    clear_a();
    w0 = wr_a;
    send_a(5'd3, 3'd5, 4, 4);
    send_a(5'd3, 3'd6, 4, 4);
    sample_pt();
    check("achg_busy_mid", 32'(busy_a), 32'(1));
    word_a(5'd4, 3'd1, 3'd2, 3'd3);
    sample_pt();
    check("achg_errs",    32'(ec_a),          32'(1));
    check("achg_flag",    32'(flag_a),        32'(1));
    check("achg_pulses",  32'(wr_a - w0),     32'(1));
    check("achg_wr_addr", 32'(lnk_a.WR_ADDR), 32'(4));
    check("achg_wr_data", 32'(lnk_a.WR_DATA), 32'(9'h0D1));
    check("achg_busy",    32'(busy_a),        32'(0));

    // Timeout inside a word, then recovery.
    clear_a();
    w0 = wr_a;
    send_a(5'd2, 3'd1, 4, 4);
    sample_pt();
    check("tmo_busy_mid", 32'(busy_a), 32'(1));
    repeat (TMO + 10) @(negedge clk);
    sample_pt();
    check("tmo_busy",   32'(busy_a),    32'(0));
    check("tmo_errs",   32'(ec_a),      32'(1));
    check("tmo_pulses", 32'(wr_a - w0), 32'(0));
    word_a(5'd2, 3'd4, 3'd5, 3'd6);
    sample_pt();
    check("tmo_rec_pulses",  32'(wr_a - w0),     32'(1));
    check("tmo_rec_wr_addr", 32'(lnk_a.WR_ADDR), 32'(2));
    check("tmo_rec_wr_data", 32'(lnk_a.WR_DATA), 32'(9'h1AC));
    check("tmo_rec_errs",    32'(ec_a),          32'(1));

    // Out-of-range flood saturates the error counter.
    clear_a();
    w0 = wr_a;
    for (int i = 0; i < 300; i++) send_a(5'd25, 3'(i), 4, 4);
    sample_pt();
    check("sat_errs",   32'(ec_a),      32'(255));
    check("sat_flag",   32'(flag_a),    32'(1));
    check("sat_pulses", 32'(wr_a - w0), 32'(0));

    // CLEAR lands in the same cycle as the error from this strobe.
    @(negedge clk);
    lnk_a.LINK_ADDR = 5'd25; lnk_a.LINK_DATA = 3'd0; lnk_a.LINK_STROBE = 1'b1;
    repeat (SS + 1) @(negedge clk);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    lnk_a.LINK_STROBE = 1'b0;
    repeat (4) @(negedge clk);
    sample_pt();
    check("clr_errs",  32'(ec_a),   32'(0));
    check("clr_flag",  32'(flag_a), 32'(0));
    check("clr_words", 32'(wc_a),   32'(0));

    // Back-to-back words at minimum strobe spacing.
    w0 = wr_a;
    send_a(5'd5, 3'd1, 3, 3);
    send_a(5'd5, 3'd1, 3, 3);
    send_a(5'd5, 3'd1, 3, 3);
    send_a(5'd6, 3'd2, 3, 3);
    sample_pt();
    check("b2b_first_pulses", 32'(wr_a - w0),     32'(1));
    check("b2b_first_addr",   32'(lnk_a.WR_ADDR), 32'(5));
    check("b2b_first_data",   32'(lnk_a.WR_DATA), 32'(9'h049));
    send_a(5'd6, 3'd3, 3, 3);
    send_a(5'd6, 3'd4, 3, 3);
    repeat (3) @(negedge clk);
    sample_pt();
    check("b2b_pulses", 32'(wr_a - w0),     32'(2));
    check("b2b_addr",   32'(lnk_a.WR_ADDR), 32'(6));
    check("b2b_data",   32'(lnk_a.WR_DATA), 32'(9'h11A));
    check("b2b_words",  32'(wc_a),          32'(2));

    // Reset in the middle of a third word.
    w0 = wr_a;
    send_a(5'd8, 3'd1, 4, 4);
    send_a(5'd8, 3'd2, 4, 4);
    sample_pt();
    check("rmid_busy", 32'(busy_a), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rmid_wr_en",   32'(lnk_a.WR_EN),   32'(0));
    check("rmid_wr_addr", 32'(lnk_a.WR_ADDR), 32'(0));
    check("rmid_wr_data", 32'(lnk_a.WR_DATA), 32'(0));
    check("rmid_words",   32'(wc_a),          32'(0));
    check("rmid_busy_rst", 32'(busy_a),       32'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sample_pt();
    check("rmid_pulses", 32'(wr_a - w0), 32'(0));
    check("rmid_errs",   32'(ec_a),      32'(0));
    check("rmid_flag",   32'(flag_a),    32'(0));

    // Single-chunk, 8-bit, 30-cell instance.
    send_b(5'd29, 8'hA5);
    sample_pt();
    check("swp_pulses1", 32'(wr_b),          32'(1));
    check("swp_addr1",   32'(lnk_b.WR_ADDR), 32'(29));
    check("swp_data1",   32'(lnk_b.WR_DATA), 32'(8'hA5));
    check("swp_words1",  32'(wc_b),          32'(1));
    send_b(5'd30, 8'hFF);
    sample_pt();
    check("swp_pulses2", 32'(wr_b),          32'(1));
    check("swp_errs2",   32'(ec_b),          32'(1));
    check("swp_flag2",   32'(flag_b),        32'(1));
    check("swp_addr2",   32'(lnk_b.WR_ADDR), 32'(29));
    send_b(5'd0, 8'h3C);
    sample_pt();
    check("swp_pulses3", 32'(wr_b),          32'(2));
    check("swp_addr3",   32'(lnk_b.WR_ADDR), 32'(0));
    check("swp_data3",   32'(lnk_b.WR_DATA), 32'(8'h3C));
    check("swp_words3",  32'(wc_b),          32'(2));
    check("swp_busy3",   32'(busy_b),        32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_maze_link_receiver
`default_nettype wire
